io_uart_tx: RTL and testbench
=============================

IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor input.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: width of each transmitted character.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous assert, active-high.
REQ-005 SHALL have port cfg_div_i, input, DIV_WIDTH bits: bit period minus one, in clk_i cycles.
REQ-006 SHALL have port cfg_stop2_i, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-007 SHALL have port cfg_parity_en_i, input, 1 bit: 1 appends an even-parity bit.
REQ-008 SHALL have port data_i, input, DATA_WIDTH bits: character from the upstream FIFO.
REQ-009 SHALL have port valid_i, input, 1 bit: data_i valid.
REQ-010 SHALL have port ready_o, output, 1 bit: transmitter accepts a character this cycle.
REQ-011 SHALL have port tx_o, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port busy_o, output, 1 bit: frame in progress.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL drive ready_o=1 only in IDLE; a transfer occurs when valid_i && ready_o at a rising edge.
REQ-015 SHALL, on a transfer, latch data_i, cfg_div_i, cfg_stop2_i and cfg_parity_en_i, and enter START on the next cycle; cfg changes mid-frame have no effect.
REQ-016 SHALL hold each bit for exactly cfg_div+1 cycles via a down-counter reloaded at every bit boundary; cfg_div=0 gives a 1-cycle bit.
REQ-017 SHALL drive tx_o=0 in START, data LSB first in DATA (3-bit-wide-or-larger bit index, DATA_WIDTH bits), XOR of latched data in PARITY, and 1 in STOP and IDLE.
REQ-018 SHALL transition DATA->PARITY when parity is latched enabled, else DATA->STOP.
REQ-019 SHALL keep STOP for 1 or 2 bit periods per latched cfg_stop2, then go to IDLE.
REQ-020 SHALL make the minimum frame-to-frame gap one IDLE cycle; a back-to-back frame's start bit begins 1 cycle after the previous stop bit ends.
REQ-021 SHALL drive busy_o=1 in every state except IDLE.
REQ-022 SHALL register tx_o so it is glitch-free.

Reset
REQ-023 SHALL, while rst_i=1, force state IDLE, tx_o=1, ready_o=1 after release, busy_o=0, and counters and data register to 0.
REQ-024 SHALL abort a frame in progress on reset assertion, with tx_o returning high asynchronously; no partial frame resumes.

Configuration
REQ-025 SHALL gate parity support on macro IO_UART_TX_PARITY_EN: when defined, REQ-007/REQ-017/REQ-018 apply.
REQ-026 SHALL, without IO_UART_TX_PARITY_EN, omit the PARITY state and logic, ignore cfg_parity_en_i (port retained, unused), and always go DATA->STOP.

Structure
REQ-027 SHALL place the FSM state enum and the default-divisor localparam in shared package io_uart_pkg.
REQ-028 SHALL implement the bit-period down-counter as sub-module io_uart_baud_cnt (load, tick outputs).

Verification
REQ-029 SHALL test: div=3, 1 stop, no parity, data=0x55 -> tx_o low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; ready_o=0 for 40 cycles.
REQ-030 SHALL test, with macro defined: parity_en=1, data=0x07, div=0 -> bits 0,1,1,1,0,0,0,0,0, parity 1, stop 1; 11-cycle frame.
REQ-031 SHALL test: stop2=1, div=1, data=0xFF -> stop high for 4 cycles before ready_o returns.
REQ-032 SHALL test: upstream FIFO preloaded with 0xA1,0xB2,0xC3, valid held -> three frames with exactly 1 idle cycle between stop end and next start.
REQ-033 SHALL test: rst_i pulsed during DATA bit 3 -> tx_o=1 and busy_o=0 immediately; next transfer produces a complete, correct frame.
REQ-034 SHALL test: cfg_div changed from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.

Source files
------------

// File: rtl/io_uart_pkg.sv
// Shared types and constants for the UART transmitter.
// The PARITY state only exists when IO_UART_TX_PARITY_EN is defined.
package io_uart_pkg;

  // 50 MHz / 115200 baud, minus one.
  localparam int unsigned DEFAULT_DIV = 433;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef IO_UART_TX_PARITY_EN
    ,ST_PARITY = 3'd4
`endif
  } uart_state_e;

  // Bit index is never narrower than 3 bits.
  function automatic int idx_width(input int w);
    return (w > 8) ? $clog2(w) : 3;
  endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// Upstream character stream into the transmitter.
// Handshake: a character moves when valid && ready are both high at a rising clk edge;
// the master holds data stable while valid is high and ready is low.
interface io_uart_tx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/io_uart_baud_cnt.sv
// Bit-period down-counter: reloads on load_i, otherwise counts down to zero and holds.
// tick_o is high on the last cycle of the current bit period.
module io_uart_baud_cnt
  import io_uart_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/io_uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional even parity, 1 or 2 stop bits.
// Parity support is compiled in only when IO_UART_TX_PARITY_EN is defined.
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic                  cfg_stop2_i,
  input  logic                  cfg_parity_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int IDX_W = idx_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  stop2_q;
  logic                  stop_second_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic                  tx_q;
  logic                  ready_q;
  logic                  busy_q;

  logic                  xfer;
  logic                  tick;
  logic                  load;
  logic [DIV_WIDTH-1:0]  load_val;

`ifdef IO_UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_parity_en;
  assign unused_parity_en = cfg_parity_en_i;
`endif

  assign xfer     = valid_i && ready_q;
  // Reload at acceptance and at every bit boundary so each bit lasts div+1 cycles.
  assign load     = xfer || ((state_q != ST_IDLE) && tick);
  assign load_val = xfer ? cfg_div_i : div_q;

  io_uart_baud_cnt #(
    .WIDTH (DIV_WIDTH)
  ) u_baud_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_o     (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      div_q         <= '0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
      bit_idx_q     <= '0;
      tx_q          <= 1'b1;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
`ifdef IO_UART_TX_PARITY_EN
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            shreg_q   <= data_i;
            div_q     <= cfg_div_i;
            stop2_q   <= cfg_stop2_i;
`ifdef IO_UART_TX_PARITY_EN
            par_en_q  <= cfg_parity_en_i;
            par_bit_q <= ^data_i;
`endif
            state_q   <= ST_START;
            tx_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_q      <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_IDX) begin
`ifdef IO_UART_TX_PARITY_EN
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q          <= 1'b1;
                stop_second_q <= 1'b0;
                state_q       <= ST_STOP;
              end
`else
              tx_q          <= 1'b1;
              stop_second_q <= 1'b0;
              state_q       <= ST_STOP;
`endif
            end else begin
              tx_q      <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
`ifdef IO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tx_q          <= 1'b1;
            stop_second_q <= 1'b0;
            state_q       <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (stop2_q && !stop_second_q) begin
              stop_second_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: table of single frames plus back-to-back,
// mid-frame divisor change and mid-frame reset sequences.
module tb_io_uart_tx;

  localparam int DIV_W = 16;
  localparam int DW    = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [DIV_W-1:0] cfg_div_i;
  logic             cfg_stop2_i;
  logic             cfg_parity_en_i;
  logic             tx_o;
  logic             busy_o;

  io_uart_tx_if #(.DATA_WIDTH(DW)) up_if ();

  io_uart_tx #(
    .DIV_WIDTH  (DIV_W),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cfg_div_i       (cfg_div_i),
    .cfg_stop2_i     (cfg_stop2_i),
    .cfg_parity_en_i (cfg_parity_en_i),
    .data_i          (up_if.data),
    .valid_i         (up_if.valid),
    .ready_o         (up_if.ready),
    .tx_o            (tx_o),
    .busy_o          (busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expand a hand-computed frame (bit 0 = start bit, sent first) into per-cycle line values.
  task automatic push_frame(input logic [11:0] bits, input int nbits, input int period);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < period; c++) exp_q.push_back(bits[b]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the DUT idle; sends one character and checks the whole frame.
  task automatic run_frame(input string name, input logic [7:0] d, input logic [15:0] dv,
                           input logic s2, input logic pe, input logic [11:0] bits,
                           input int nbits, input int chg_at, input logic [15:0] chg_div);
    int k;
    logic [0:0] e;
    k = 0;
    exp_q.delete();
    push_frame(bits, nbits, int'(dv) + 1);
    up_if.data      = d;
    up_if.valid     = 1'b1;
    cfg_div_i       = dv;
    cfg_stop2_i     = s2;
    cfg_parity_en_i = pe;
    check({name, "/ready_before"}, 32'(up_if.ready), 32'd1);
    @(posedge clk_i); #1;
    // Scramble inputs after acceptance: the frame must use the latched values.
    up_if.valid     = 1'b0;
    up_if.data      = ~d;
    cfg_stop2_i     = ~s2;
    cfg_parity_en_i = ~pe;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (k == chg_at) cfg_div_i = chg_div;
      check($sformatf("%s/tx[%0d]", name, k), 32'(tx_o), 32'(e));
      check($sformatf("%s/ready[%0d]", name, k), 32'(up_if.ready), 32'd0);
      check($sformatf("%s/busy[%0d]", name, k), 32'(busy_o), 32'd1);
      k++;
      @(posedge clk_i); #1;
    end
    check({name, "/idle_tx"}, 32'(tx_o), 32'd1);
    check({name, "/idle_ready"}, 32'(up_if.ready), 32'd1);
    check({name, "/idle_busy"}, 32'(busy_o), 32'd0);
    cfg_stop2_i     = s2;
    cfg_parity_en_i = pe;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [7:0]  data;
    logic [15:0] div;
    logic        stop2;
    logic        par;
    logic [11:0] bits;
    int          nbits;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] fifo_q[$];

  initial begin
    logic rdy_s;

    vecs.push_back('{"d55_div3",       8'h55, 16'd3, 1'b0, 1'b0, 12'h2AA, 10});
    vecs.push_back('{"dFF_stop2_div1", 8'hFF, 16'd1, 1'b1, 1'b0, 12'h7FE, 11});
    vecs.push_back('{"d00_div0",       8'h00, 16'd0, 1'b0, 1'b0, 12'h200, 10});
    vecs.push_back('{"d3C_stop2_div2", 8'h3C, 16'd2, 1'b1, 1'b0, 12'h678, 11});
`ifdef IO_UART_TX_PARITY_EN
    vecs.push_back('{"d07_par_div0",   8'h07, 16'd0, 1'b0, 1'b1, 12'h60E, 11});
    vecs.push_back('{"d03_par_stop2",  8'h03, 16'd1, 1'b1, 1'b1, 12'hC06, 12});
`else
    vecs.push_back('{"d07_par_ignored", 8'h07, 16'd0, 1'b0, 1'b1, 12'h20E, 10});
`endif

    // Reset
    rst_i           = 1'b1;
    up_if.data      = '0;
    up_if.valid     = 1'b0;
    cfg_div_i       = '0;
    cfg_stop2_i     = 1'b0;
    cfg_parity_en_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset/tx", 32'(tx_o), 32'd1);
    check("reset/busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("post_reset/ready", 32'(up_if.ready), 32'd1);
    check("post_reset/tx", 32'(tx_o), 32'd1);

    // No valid: line stays idle
    repeat (3) begin
      @(posedge clk_i); #1;
      check("no_valid/tx", 32'(tx_o), 32'd1);
      check("no_valid/busy", 32'(busy_o), 32'd0);
    end

    foreach (vecs[i])
      run_frame(vecs[i].name, vecs[i].data, vecs[i].div, vecs[i].stop2, vecs[i].par,
                vecs[i].bits, vecs[i].nbits, -1, 16'd0);

    // Back-to-back frames with valid held: one idle cycle between frames
    fifo_q = '{8'hB2, 8'hC3};
    exp_q.delete();
    push_frame(12'h342, 10, 2); exp_q.push_back(1'b1);
    push_frame(12'h364, 10, 2); exp_q.push_back(1'b1);
    push_frame(12'h386, 10, 2);
    repeat (3) exp_q.push_back(1'b1);
    cfg_div_i   = 16'd1;
    cfg_stop2_i = 1'b0;
    cfg_parity_en_i = 1'b0;
    up_if.data  = 8'hA1;
    up_if.valid = 1'b1;
    rdy_s = up_if.ready;
    for (int k = 0; exp_q.size() > 0; k++) begin
      logic [0:0] e;
      @(posedge clk_i); #1;
      if (rdy_s && up_if.valid) begin
        if (fifo_q.size() > 0) up_if.data = fifo_q.pop_front();
        else up_if.valid = 1'b0;
      end
      e = exp_q.pop_front();
      check($sformatf("b2b/tx[%0d]", k), 32'(tx_o), 32'(e));
      rdy_s = up_if.ready;
    end
    check("b2b/fifo_drained", 32'(fifo_q.size()), 32'd0);
    check("b2b/end_ready", 32'(up_if.ready), 32'd1);

    // Divisor change mid-frame: current frame keeps 4-cycle bits, next uses 8
    run_frame("div_chg_cur", 8'h3C, 16'd3, 1'b0, 1'b0, 12'h278, 10, 10, 16'd7);
    run_frame("div_chg_next", 8'hC5, 16'd7, 1'b0, 1'b0, 12'h38A, 10, -1, 16'd0);

    // Reset during data bit 3 of a div=3 frame
    cfg_div_i   = 16'd3;
    cfg_stop2_i = 1'b0;
    up_if.data  = 8'h55;
    up_if.valid = 1'b1;
    @(posedge clk_i); #1;
    up_if.valid = 1'b0;
    repeat (17) begin
      @(posedge clk_i); #1;
    end
    check("rst_mid/tx_before", 32'(tx_o), 32'd0);
    check("rst_mid/busy_before", 32'(busy_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_mid/tx_async", 32'(tx_o), 32'd1);
    check("rst_mid/busy_async", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      check("rst_mid/idle_tx", 32'(tx_o), 32'd1);
      check("rst_mid/idle_ready", 32'(up_if.ready), 32'd1);
      check("rst_mid/idle_busy", 32'(busy_o), 32'd0);
    end
    run_frame("after_rst", 8'h55, 16'd3, 1'b0, 1'b0, 12'h2AA, 10, -1, 16'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
